target_box_extract: RTL and testbench

// - Producer of the target box lists that the overlay drawer consumes. It scans the binary mask stream
//   (per_img_Bit) and grows up to N_TGT bounding boxes from horizontal runs of 1-pixels.
// - At each frame start it publishes the previous frame's boxes as target_xy / target_out.
// - Sits after binarisation, in parallel with the video path feeding the drawer.

---
 rtl/target_box_extract.sv | 276 +++++++++++++++++++++++++++
 tb/tb_target_box_extract.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/target_box_extract.sv
// target_box_extract: grows up to N_TGT bounding boxes from horizontal runs of
// 1-pixels in a binary mask stream and publishes the previous frame's boxes at
// each frame start.
// Optional build macro TARGET_MIN_SIZE_FILTER_EN: when defined, boxes smaller
// than MIN_W x MIN_H are published as invalid.
module target_box_extract #(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int N_TGT     = 10,
    parameter int GAP_X     = 4,
    parameter int GAP_Y     = 2,
    parameter int MIN_W     = 8,
    parameter int MIN_H     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           per_frame_vsync,
    input  logic                           per_frame_href,
    input  logic                           per_frame_clken,
    input  logic                           per_img_Bit,
    output logic [48*N_TGT-1:0]            target_xy,
    output logic [24*N_TGT-1:0]            target_out,
    output logic [N_TGT-1:0]               target_valid,
    output logic [$clog2(N_TGT+1)-1:0]     target_cnt,
    output logic                           frame_done,
    output logic                           overflow
);

    localparam int CNT_W = $clog2(N_TGT+1);
    localparam logic [11:0] X_LAST = 12'(IMG_HDISP - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_VDISP - 1);

    typedef enum logic [2:0] {S_WAIT, S_SCAN, S_FLUSH, S_PUBLISH, S_CLEAR} state_t;

    state_t state_q, state_d;

    // href is carried for interface compatibility only; pixel counting uses clken
    logic unused_href;
    assign unused_href = per_frame_href;

    logic vsync_q;
    logic vs_rise;
    assign vs_rise = per_frame_vsync & ~vsync_q;

    logic [11:0] x_q, y_q;

    // open-run tracking
    logic        open_q, open_d;
    logic [11:0] open_s_q, open_s_d;
    logic        close_now;
    logic [11:0] close_s, close_e;

    // closed run waiting to be applied to the slots
    logic        rv_q;
    logic [11:0] rs_q, re_q, ry_q;

    // box slots
    logic [N_TGT-1:0]        occ_q, occ_d;
    logic [N_TGT-1:0][11:0]  up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic                    ovf_q, ovf_d;

    // values that PUBLISH registers
    logic [48*N_TGT-1:0] pub_xy;
    logic [24*N_TGT-1:0] pub_out;
    logic [N_TGT-1:0]    pub_valid;
    logic [CNT_W-1:0]    pub_cnt;

    // frame-sync edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vsync_q <= 1'b0;
        else     vsync_q <= per_frame_vsync;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_WAIT;
        else     state_q <= state_d;
    end

    // FSM next state: a vsync rise only matters in WAIT and SCAN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:    if (vs_rise) state_d = S_SCAN;
            S_SCAN:    if (vs_rise) state_d = S_FLUSH;
            S_FLUSH:   state_d = S_PUBLISH;
            S_PUBLISH: state_d = S_CLEAR;
            S_CLEAR:   state_d = S_SCAN;
            default:   state_d = S_WAIT;
        endcase
    end

    // pixel position counters; vsync rise restarts them at the origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (vs_rise) begin
            x_q <= '0;
            y_q <= '0;
        end else if (per_frame_clken) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                if (y_q != Y_LAST) y_q <= y_q + 12'd1;
            end else begin
                x_q <= x_q + 12'd1;
            end
        end
    end

    // run detection: a run is forcibly closed at the last column of a line
    always_comb begin
        open_d    = open_q;
        open_s_d  = open_s_q;
        close_now = 1'b0;
        close_s   = open_s_q;
        close_e   = x_q - 12'd1;
        if (state_q != S_SCAN) begin
            open_d = 1'b0;
        end else if (per_frame_clken) begin
            if (per_img_Bit) begin
                if (x_q == X_LAST) begin
                    close_now = 1'b1;
                    close_s   = open_q ? open_s_q : x_q;
                    close_e   = X_LAST;
                    open_d    = 1'b0;
                end else if (!open_q) begin
                    open_d   = 1'b1;
                    open_s_d = x_q;
                end
            end else if (open_q) begin
                close_now = 1'b1;
                open_d    = 1'b0;
            end
        end
    end

    // open-run state and the registered closed run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q   <= 1'b0;
            open_s_q <= '0;
            rv_q     <= 1'b0;
            rs_q     <= '0;
            re_q     <= '0;
            ry_q     <= '0;
        end else begin
            open_q   <= open_d;
            open_s_q <= open_s_d;
            rv_q     <= close_now;
            if (close_now) begin
                rs_q <= close_s;
                re_q <= close_e;
                ry_q <= y_q;
            end
        end
    end

    // slot update: extend the lowest matching slot, else allocate the lowest free one
    always_comb begin
        logic matched, placed;
        occ_d   = occ_q;
        up_d    = up_q;
        down_d  = down_q;
        left_d  = left_q;
        right_d = right_q;
        ovf_d   = ovf_q;
        matched = 1'b0;
        placed  = 1'b0;
        if (state_q == S_CLEAR) begin
            occ_d = '0;
            ovf_d = 1'b0;
        end else if (rv_q) begin
            for (int k = 0; k < N_TGT; k++) begin
                if (!matched && occ_q[k]
                    && ({1'b0, rs_q} <= {1'b0, right_q[k]} + 13'(GAP_X))
                    && ({1'b0, re_q} + 13'(GAP_X) >= {1'b0, left_q[k]})
                    && ({1'b0, ry_q} <= {1'b0, down_q[k]} + 13'(GAP_Y))) begin
                    matched = 1'b1;
                    if (rs_q < left_q[k])  left_d[k]  = rs_q;
                    if (re_q > right_q[k]) right_d[k] = re_q;
                    down_d[k] = ry_q;
                end
            end
            if (!matched) begin
                for (int k = 0; k < N_TGT; k++) begin
                    if (!placed && !occ_q[k]) begin
                        placed     = 1'b1;
                        occ_d[k]   = 1'b1;
                        up_d[k]    = ry_q;
                        down_d[k]  = ry_q;
                        left_d[k]  = rs_q;
                        right_d[k] = re_q;
                    end
                end
                if (!placed) ovf_d = 1'b1;
            end
        end
    end

    // slot storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= '0;
            up_q    <= '0;
            down_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            up_q    <= up_d;
            down_q  <= down_d;
            left_q  <= left_d;
            right_q <= right_d;
            ovf_q   <= ovf_d;
        end
    end

`ifndef TARGET_MIN_SIZE_FILTER_EN
    // size thresholds only matter when the filter is built in
    localparam int UNUSED_MIN_SZ = MIN_W + MIN_H;
`endif

    // publish image of the slots: centres, zeroed invalid slots, popcount
    always_comb begin
        logic [12:0] sx, sy;
        logic        vk;
        pub_xy    = '0;
        pub_out   = '0;
        pub_valid = '0;
        pub_cnt   = '0;
        sx        = '0;
        sy        = '0;
        vk        = 1'b0;
        for (int k = 0; k < N_TGT; k++) begin
`ifdef TARGET_MIN_SIZE_FILTER_EN
            vk = occ_q[k]
                 && ({1'b0, right_q[k]} - {1'b0, left_q[k]} + 13'd1 >= 13'(MIN_W))
                 && ({1'b0, down_q[k]}  - {1'b0, up_q[k]}   + 13'd1 >= 13'(MIN_H));
`else
            vk = occ_q[k];
`endif
            sx = {1'b0, left_q[k]} + {1'b0, right_q[k]};
            sy = {1'b0, up_q[k]} + {1'b0, down_q[k]};
            pub_valid[k] = vk;
            if (vk) begin
                pub_xy[k*48 +: 48] = {up_q[k], down_q[k], left_q[k], right_q[k]};
                pub_out[k*24 +: 24] = {sx[12:1], sy[12:1]};
                pub_cnt = pub_cnt + CNT_W'(1);
            end
        end
    end

    // output registers: refreshed only in PUBLISH, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_xy    <= '0;
            target_out   <= '0;
            target_valid <= '0;
            target_cnt   <= '0;
            overflow     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= (state_q == S_PUBLISH);
            if (state_q == S_PUBLISH) begin
                target_xy    <= pub_xy;
                target_out   <= pub_out;
                target_valid <= pub_valid;
                target_cnt   <= pub_cnt;
                overflow     <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_target_box_extract.sv
// Scoreboard bench for target_box_extract on a reduced 160x64 raster.
module tb_target_box_extract;

    localparam int H = 160;
    localparam int V = 64;
    localparam int N = 10;

    localparam int P_NONE = 0, P_BLOB = 1, P_TWO = 2, P_OVF = 3, P_EDGE = 4, P_SMALL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0, pbit = 1'b0;
    logic [48*N-1:0] target_xy;
    logic [24*N-1:0] target_out;
    logic [N-1:0]    target_valid;
    logic [3:0]      target_cnt;
    logic            frame_done, overflow;

    target_box_extract #(.IMG_HDISP(H), .IMG_VDISP(V), .N_TGT(N),
                         .GAP_X(4), .GAP_Y(2), .MIN_W(8), .MIN_H(8)) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_Bit(pbit),
        .target_xy(target_xy), .target_out(target_out),
        .target_valid(target_valid), .target_cnt(target_cnt),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [48*N-1:0] xy;
        logic [24*N-1:0] out;
        logic [N-1:0]    valid;
        logic [3:0]      cnt;
        logic            ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int n_tests = 0, n_fail = 0;
    int cyc = 0, rise_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [479:0] act, input logic [479:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic exp_clear();
        cur.xy = '0; cur.out = '0; cur.valid = '0; cur.cnt = '0; cur.ovf = 1'b0;
    endtask

    // expected box in slot k; centre is the truncated midpoint
    task automatic exp_box(input int k, input int u, input int d, input int l, input int r);
        logic [47:0] b;
        logic [23:0] c;
        b = {12'(u), 12'(d), 12'(l), 12'(r)};
        c = {12'((l + r) / 2), 12'((u + d) / 2)};
        cur.xy[k*48 +: 48] = b;
        cur.out[k*24 +: 24] = c;
        cur.valid[k] = 1'b1;
        cur.cnt = cur.cnt + 4'd1;
    endtask

    task automatic exp_push(input logic ovf);
        cur.ovf = ovf;
        exp_q.push_back(cur);
    endtask

    function automatic logic pix(input int p, input int x, input int y);
        case (p)
            P_BLOB:  return (x >= 100 && x <= 149 && y >= 20 && y <= 29);
            P_TWO:   return (y >= 10 && y <= 19 && ((x >= 50 && x <= 59) || (x >= 100 && x <= 109)))
                         || (x >= 130 && x <= 139 && ((y >= 10 && y <= 12) || (y >= 14 && y <= 15)))
                         || (y >= 23 && y <= 25 && x >= 50 && x <= 59);
            P_OVF:   return (y == 3 && x >= 10 && x <= 130 && ((x - 10) % 12) == 0);
            P_EDGE:  return (y == 5 && x >= 150) || (y == 6 && x <= 3);
            P_SMALL: return (x >= 40 && x <= 41 && y >= 4 && y <= 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic scan(input int p, input int rows);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < H; x++) begin
                @(posedge clk); #1;
                clken = 1'b1; href = 1'b1; pbit = pix(p, x, y);
            end
        end
        @(posedge clk); #1;
        clken = 1'b0; href = 1'b0; pbit = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(posedge clk); #1;
        clken = 1'b0; pbit = 1'b0; vsync = 1'b1;
        rise_cyc = cyc + 1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_timeout: %0d publishes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_xy"},    480'(target_xy), '0);
        chk({tag, "_out"},   480'(target_out), '0);
        chk({tag, "_valid"}, 480'(target_valid), '0);
        chk({tag, "_cnt"},   480'(target_cnt), '0);
        chk({tag, "_ovf_done"}, 480'({overflow, frame_done}), '0);
    endtask

    // monitor: every frame_done pops one expected publish
    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: frame_done=1 at cycle %0d, expected 0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency", 480'(cyc - rise_cyc), 480'(2));
                chk("xy",      480'(target_xy), 480'(e.xy));
                chk("out",     480'(target_out), 480'(e.out));
                chk("valid",   480'(target_valid), 480'(e.valid));
                chk("cnt",     480'(target_cnt), 480'(e.cnt));
                chk("ovf",     480'(overflow), 480'(e.ovf));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // first vsync only arms scanning: nothing published
        vsync_pulse();
        repeat (4) @(posedge clk);

        // single blob
        scan(P_BLOB, 32);
        exp_clear(); exp_box(0, 20, 29, 100, 149); exp_push(1'b0);
        vsync_pulse(); wait_drain();

        // two side-by-side blobs, a 3-row gap split and a 1-row gap merge
        scan(P_TWO, 27);
        exp_clear();
        exp_box(0, 10, 19, 50, 59);
        exp_box(1, 10, 19, 100, 109);
        exp_box(2, 10, 15, 130, 139);
        exp_box(3, 23, 25, 50, 59);
        exp_push(1'b0);
        vsync_pulse(); wait_drain();

        // eleven runs on one row: the last one overflows
        scan(P_OVF, 5);
        exp_clear();
        for (int k = 0; k < N; k++) exp_box(k, 3, 3, 10 + 12*k, 10 + 12*k);
        exp_push(1'b1);
        vsync_pulse(); wait_drain();

        // clean frame clears overflow
        scan(P_NONE, 3);
        exp_clear(); exp_push(1'b0);
        vsync_pulse(); wait_drain();

        // run ending at the last column, next row starts at column 0
        scan(P_EDGE, 8);
        exp_clear();
        exp_box(0, 5, 5, 150, 159);
        exp_box(1, 6, 6, 0, 3);
        exp_push(1'b0);
        vsync_pulse(); wait_drain();

        // 2x2 blob, below the size threshold
        scan(P_SMALL, 8);
        exp_clear();
`ifndef TARGET_MIN_SIZE_FILTER_EN
        exp_box(0, 4, 5, 40, 41);
`endif
        exp_push(1'b0);
        vsync_pulse(); wait_drain();

        // reset in the middle of a blob frame
        scan(P_BLOB, 25);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        vsync_pulse();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_zero("after_rst");

        scan(P_BLOB, 32);
        exp_clear(); exp_box(0, 20, 29, 100, 149); exp_push(1'b0);
        vsync_pulse(); wait_drain();

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
